// File: rtl/noc_pe_pkg.sv
// rtl/noc_pe_pkg.sv - shared pattern codes, FSM states and flit field layout for the NoC traffic PE
package noc_pe_pkg;

    typedef enum logic [2:0] {
        PAT_RANDOM     = 3'd0,
        PAT_COMPLEMENT = 3'd1,
        PAT_REVERSE    = 3'd2,
        PAT_ROTATION   = 3'd3,
        PAT_TRANSPOSE  = 3'd4,
        PAT_TORNADO    = 3'd5,
        PAT_NEIGHBOUR  = 3'd6,
        PAT_RANDOM_ALT = 3'd7
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Flit layout, LSB first: ts | 1'b0 | dest | head | valid
    function automatic int flit_width(input int aw, input int tw);
        return tw + aw + 3;
    endfunction

    function automatic int dest_lsb(input int tw);
        return tw + 1;
    endfunction

    function automatic int dest_msb(input int aw, input int tw);
        return tw + aw;
    endfunction

    function automatic logic [15:0] lfsr_seed(input int seed, input int addr);
        logic [15:0] s;
        s = 16'(seed ^ addr);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/noc_pe_lfsr.sv
// rtl/noc_pe_lfsr.sv - 16-bit Galois LFSR used for random destinations and the injection gate
module noc_pe_lfsr
    import noc_pe_pkg::*;
#(
    parameter logic [15:0] Seed = 16'h0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= Seed;
        end else if (en) begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/noc_traffic_pe.sv
// rtl/noc_traffic_pe.sv - NoC traffic generator/sink PE; define PE_LATENCY_STATS_EN to keep latency stats
module noc_traffic_pe
    import noc_pe_pkg::*;
#(
    parameter int Address      = 0,
    parameter int AddressWidth = 2,
    parameter int NumPE        = 4,
    parameter int TsWidth      = 32,
    parameter int PktLimit     = 20,
    parameter int Seed         = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_start,
    input  logic [2:0]                        i_pattern,
    input  logic [7:0]                        i_rate,
    output logic [TsWidth+AddressWidth+2:0]   o_data,
    output logic                              o_data_valid,
    input  logic                              i_data_ready,
    input  logic [TsWidth+AddressWidth+2:0]   i_data,
    input  logic                              i_data_valid,
    output logic                              o_data_ready,
    output logic                              o_busy,
    output logic                              o_done,
    output logic [31:0]                       o_sent_cnt,
    output logic [31:0]                       o_recv_cnt,
    output logic [15:0]                       o_err_cnt,
    output logic [47:0]                       o_lat_sum,
    output logic [TsWidth-1:0]                o_lat_max
);

    localparam int AW   = AddressWidth;
    localparam int FW   = flit_width(AddressWidth, TsWidth);
    localparam int DLSB = dest_lsb(TsWidth);
    localparam int DMSB = dest_msb(AddressWidth, TsWidth);

    localparam logic [AW-1:0] ADDR_BITS     = AW'(Address);
    localparam logic [AW-1:0] TORNADO_DEST  = AW'((Address + (NumPE + 1) / 2) % NumPE);
    localparam logic [AW-1:0] NEIGHBOR_DEST = AW'((Address + 1) % NumPE);
    localparam logic [32:0]   LIMIT         = 33'(PktLimit);
    localparam logic [31:0]   LAST_IDX      = 32'(PktLimit - 1);

    state_e             state;
    logic [TsWidth-1:0] ts_cnt;
    logic [15:0]        lfsr;
    logic [AW-1:0]      gen_dest;
    logic [AW-1:0]      rnd;
    logic [32:0]        issued;
    logic               gate;
    logic               accept;
    logic               load;
    logic               last_accept;
    logic [AW-1:0]      rx_dest;
    logic               misc_unused;

    assign o_data_ready = 1'b1;

    noc_pe_lfsr #(
        .Seed (lfsr_seed(Seed, Address))
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .state (lfsr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
        end
    end

    always_comb begin
        rnd      = lfsr[15 -: AW];
        gen_dest = ADDR_BITS;
        case (pattern_e'(i_pattern))
            PAT_COMPLEMENT: gen_dest = ~ADDR_BITS;
            PAT_REVERSE: begin
                for (int j = 0; j < AW; j++) gen_dest[j] = ADDR_BITS[AW-1-j];
            end
            PAT_ROTATION: begin
                for (int j = 0; j < AW; j++) gen_dest[j] = ADDR_BITS[(j + 1) % AW];
            end
            PAT_TRANSPOSE: begin
                for (int j = 0; j < AW; j++) gen_dest[j] = ADDR_BITS[(j + AW / 2) % AW];
            end
            PAT_TORNADO:   gen_dest = TORNADO_DEST;
            PAT_NEIGHBOUR: gen_dest = NEIGHBOR_DEST;
            default: begin
                // Fold out-of-range random ids back into 0..NumPE-1 with one subtraction
                if (int'(rnd) >= NumPE) begin
                    gen_dest = AW'(int'(rnd) - NumPE);
                end else begin
                    gen_dest = rnd;
                end
            end
        endcase
    end

    // A pending flit counts as issued so the run never overshoots PktLimit
    assign issued      = {1'b0, o_sent_cnt} + 33'(o_data_valid);
    assign gate        = (i_rate == 8'hFF) || (lfsr[7:0] < i_rate);
    assign accept      = o_data_valid && i_data_ready;
    assign load        = (state == ST_RUN) && (!o_data_valid || i_data_ready) && (issued < LIMIT) && gate;
    assign last_accept = accept && (o_sent_cnt == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_sent_cnt   <= '0;
            o_data_valid <= 1'b0;
            o_data       <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept) begin
                        o_sent_cnt <= o_sent_cnt + 1'b1;
                    end
                    if (last_accept) begin
                        state  <= ST_DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                default: begin
                    if (i_start) begin
                        state      <= ST_RUN;
                        o_busy     <= 1'b1;
                        o_done     <= 1'b0;
                        o_sent_cnt <= '0;
                    end
                end
            endcase

            if (load) begin
                o_data_valid <= 1'b1;
                o_data       <= {2'b11, gen_dest, 1'b0, ts_cnt};
            end else if (accept) begin
                o_data_valid <= 1'b0;
            end
        end
    end

    assign rx_dest = i_data[DMSB:DLSB];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_recv_cnt <= '0;
            o_err_cnt  <= '0;
        end else if (i_data_valid) begin
            o_recv_cnt <= o_recv_cnt + 1'b1;
            if ((rx_dest != ADDR_BITS) && (o_err_cnt != 16'hFFFF)) begin
                o_err_cnt <= o_err_cnt + 1'b1;
            end
        end
    end

`ifdef PE_LATENCY_STATS_EN
    logic [TsWidth-1:0] rx_lat;

    assign rx_lat = ts_cnt - i_data[TsWidth-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_lat_sum <= '0;
            o_lat_max <= '0;
        end else if (i_data_valid) begin
            o_lat_sum <= o_lat_sum + 48'(rx_lat);
            if (rx_lat > o_lat_max) begin
                o_lat_max <= rx_lat;
            end
        end
    end
`else
    assign o_lat_sum = '0;
    assign o_lat_max = '0;
`endif

    // Header bits of incoming flits and the unused LFSR middle bits carry no state here
    assign misc_unused = ^{i_data[FW-1:DMSB+1], i_data[TsWidth:0], lfsr};

endmodule
